// File: rtl/pll_lock_sequencer.sv
// PLL start-up sequencer: holds PLL reset, waits for a stable lock, supervises loss of lock with bounded retries.
// Optional macro PLL_BYPASS_FALLBACK_EN: exhausted retries run the pixel path on the bypassed reference clock.
module pll_lock_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 16000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int LOSS_FILTER_CYCLES  = 4,
  parameter int MAX_RETRIES         = 3,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clock_in,
  input  logic          reset_n,
  input  logic          pll_locked,
  input  logic          relock_req,
  output logic          pll_resetb,
  output logic          pll_bypass,
  output logic          sys_reset_n,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_count
);

  localparam int MAX_AB  = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD  = (STABLE_CYCLES > LOSS_FILTER_CYCLES) ? STABLE_CYCLES : LOSS_FILTER_CYCLES;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LOSS_LAST    = CW'(LOSS_FILTER_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam logic FAULT_RUN = 1'b1;
`else
  localparam logic FAULT_RUN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_STABLE     = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

  logic          r_sync1;
  logic          r_locked_s;
  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [RW-1:0] r_retry;
  logic [RW-1:0] w_retry_nx;
  logic          r_pll_resetb;
  logic          r_sys_reset_n;
  logic          r_ready;
  logic          r_fault;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // Next state and retry bookkeeping; a restart request outranks every other transition
  always_comb begin
    w_state_nx = r_state;
    w_retry_nx = r_retry;
    if (relock_req && (r_state != S_RESET_HOLD)) begin
      w_state_nx = S_RESET_HOLD;
      w_retry_nx = {RW{1'b0}};
    end else begin
      case (r_state)
        S_RESET_HOLD: begin
          if (r_cnt == HOLD_LAST) w_state_nx = S_WAIT_LOCK;
          else                    w_state_nx = S_RESET_HOLD;
        end
        S_WAIT_LOCK: begin
          if (r_locked_s) begin
            w_state_nx = S_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            if (r_retry == RETRY_LIMIT) begin
              w_state_nx = S_FAULT;
            end else begin
              w_state_nx = S_RESET_HOLD;
              w_retry_nx = r_retry + RW'(1);
            end
          end else begin
            w_state_nx = S_WAIT_LOCK;
          end
        end
        S_STABLE: begin
          if (!r_locked_s) begin
            w_state_nx = S_WAIT_LOCK;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nx = S_RUN;
            w_retry_nx = {RW{1'b0}};
          end else begin
            w_state_nx = S_STABLE;
          end
        end
        S_RUN: begin
          if (!r_locked_s && (r_cnt == LOSS_LAST)) w_state_nx = S_RESET_HOLD;
          else                                     w_state_nx = S_RUN;
        end
        S_FAULT: w_state_nx = S_FAULT;
        default: w_state_nx = S_RESET_HOLD;
      endcase
    end
  end

  // Shared counter: restarts on any state change; in RUN it measures the current unlocked run
  always_comb begin
    w_cnt_nx = {CW{1'b0}};
    if (w_state_nx != r_state) begin
      w_cnt_nx = {CW{1'b0}};
    end else begin
      case (r_state)
        S_RESET_HOLD, S_WAIT_LOCK, S_STABLE: w_cnt_nx = r_cnt + CW'(1);
        S_RUN: begin
          if (r_locked_s) w_cnt_nx = {CW{1'b0}};
          else            w_cnt_nx = r_cnt + CW'(1);
        end
        default: w_cnt_nx = {CW{1'b0}};
      endcase
    end
  end

  // State, counters and outputs; outputs decode the next state so they change with the state
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RESET_HOLD;
      r_cnt         <= {CW{1'b0}};
      r_retry       <= {RW{1'b0}};
      r_pll_resetb  <= 1'b0;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_retry       <= w_retry_nx;
      r_pll_resetb  <= (w_state_nx == S_WAIT_LOCK) || (w_state_nx == S_STABLE) || (w_state_nx == S_RUN);
      r_sys_reset_n <= (w_state_nx == S_RUN) || (FAULT_RUN && (w_state_nx == S_FAULT));
      r_ready       <= (w_state_nx == S_RUN);
      r_fault       <= (w_state_nx == S_FAULT);
    end
  end

`ifdef PLL_BYPASS_FALLBACK_EN
  logic r_pll_bypass;

  // Bypass follows the fault condition so the pixel path runs on the reference clock
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) r_pll_bypass <= 1'b0;
    else          r_pll_bypass <= (w_state_nx == S_FAULT);
  end

  assign pll_bypass = r_pll_bypass;
`else
  assign pll_bypass = 1'b0;
`endif

  assign pll_resetb  = r_pll_resetb;
  assign sys_reset_n = r_sys_reset_n;
  assign ready       = r_ready;
  assign fault       = r_fault;
  assign retry_count = r_retry;

endmodule
